nx1_vram_arb: RTL and testbench
===============================

Name: nx1_vram_arb

Overview:
- Single-clock shared video/text RAM that generalises the two-port 2Kx8 RAM to AW address bits and DW data bits.
- A CPU port and a video fetch port arbitrate cycle by cycle for one internal synchronous-read array.
- The CPU port uses a level-request/acknowledge handshake with a wait output, so the Z80 bus can be stretched.
- A starvation limit guarantees CPU progress while the CRTC holds continuous fetch.

Parameters:
AW, 11, address width; depth is 2**AW words
DW, 8, data width
STARVE_MAX, 8, maximum consecutive cycles a pending CPU request loses to video before it is forced through (1..15)

Ports:
CLK  in  1  system clock
RST_n  in  1  asynchronous active-low reset
CA  in  AW  CPU address
CDI  in  DW  CPU write data
CDO  out  DW  CPU read data, valid while CACK=1
CCS  in  1  CPU chip select; request = CCS & (CWE | CRD)
CWE  in  1  CPU write strobe
CRD  in  1  CPU read strobe
CWAIT  out  1  combinational; 1 while a CPU request is outstanding and not yet acknowledged
CACK  out  1  one-cycle acknowledge pulse
VREQ  in  1  video fetch request, one word per cycle
VA  in  AW  video address
VDO  out  DW  video read data
VVALID  out  1  VDO holds data for the VREQ of the previous cycle
VMISS  out  1  one-cycle pulse: the previous-cycle VREQ was dropped for the CPU
BUSY  out  1  clear sequence running (tied 0 without the optional feature)

Behaviour:
- Reset is asynchronous and active-low: RST_n low clears CDO, VDO, VVALID, CACK, VMISS, the starve counter, the done flag and the arbiter state. RAM contents are not reset unless the optional feature is compiled in.
- The array completes one access per cycle; only the slot winner accesses the array in that cycle.
- cpu_req = CCS & (CWE | CRD) & ~done.
- done is set in the CPU grant cycle and cleared in any cycle with CCS=0. One CCS assertion is served exactly once, however long it is held.
- Arbitration, per cycle:
  - VREQ=1 and (cpu_req=0 or starve < STARVE_MAX): video wins. If cpu_req=1, starve increments, saturating at STARVE_MAX.
  - cpu_req=1 and (VREQ=0 or starve = STARVE_MAX): CPU wins and starve resets to 0. If VREQ=1 in this cycle, VMISS=1 on the next cycle and VVALID=0.
  - Neither port requesting: idle; VVALID=0 and CACK=0 on the next cycle.
- Video grant at cycle t: VDO = mem[VA(t)] and VVALID=1 at t+1.
- VDO holds its last value when VVALID=0.
- CPU grant at cycle t:
  - CACK=1 at t+1.
  - Write (CWE=1): mem[CA] <= CDI at the t edge. CDO is unchanged.
  - Read (CRD=1, CWE=0): CDO = mem[CA(t)] at t+1 and holds until the next CPU read.
  - CWE and CRD both 1: treated as a write.
- CWAIT = cpu_req & ~(CPU granted this cycle). The master holds CA, CDI and the strobes stable while CWAIT=1.
- Read-during-write on the same address across ports (video reads a word the CPU wrote in an earlier cycle): new data. Same-cycle access is impossible because the arbiter grants only one port.
- CCS dropped before grant: the request is abandoned with no write and no CACK, and starve resets to 0.
- RST_n asserted mid-request: the request is discarded. If CCS is still high after release, it is served again because done=0, so a write executes twice.
- Addresses wrap naturally modulo 2**AW; there is no out-of-range case.

Optional Feature:
- Macro: NX1_VRAM_CLEAR_EN.
- Defined:
  - After RST_n release, a clear engine writes CLEAR_VALUE = 0 to addresses 0..2**AW-1, one word per cycle, with BUSY=1.
  - During the clear, every CPU request sees CWAIT=1 and no grant. Every VREQ returns VVALID=1 with VDO=0.
  - BUSY falls the cycle after address 2**AW-1 is written; normal arbitration starts on that cycle.
  - Reset during the clear restarts it from address 0.
- Undefined: BUSY is tied 0, there is no clear engine, and the RAM powers up with undefined contents.

Test Plan:
- CPU write then read, VREQ=0: write CA=0x123 CDI=0xA5 -> CACK at t+1, CWAIT=0 at t. Read CA=0x123 -> CDO=0xA5 with CACK.
- Collision, STARVE_MAX=8: VREQ=1 continuously while CPU holds a read of 0x010 -> CWAIT=1 for exactly 8 cycles; CPU grant on the 9th; VMISS=1 the following cycle; video resumes next cycle.
- Held CCS: CCS=1 and CWE=1 for 5 cycles with CDI=0x3C to 0x7FF -> exactly one CACK; an intermediate CDI change is ignored after grant; memory holds 0x3C.
- Video streaming: VA=0..15 on consecutive cycles, memory preloaded with value = address -> VDO=0..15 on cycles 1..16, VVALID=1 throughout.
- Abandon and reset: CPU write request loses 3 cycles to video, then CCS drops -> no CACK and memory is unchanged. Pulse RST_n low mid-request -> all outputs 0 immediately.
- With NX1_VRAM_CLEAR_EN: preload 0xFF, reset -> BUSY=1 for exactly 2048 cycles (AW=11) and CPU waits; every location then reads 0x00.

Source files
------------

// File: rtl/nx1_vram_arb.sv
// nx1_vram_arb: shared video/text RAM with a CPU wait/ack port and a video fetch port arbitrated per cycle.
//
// Parameters: AW address bits (depth 2**AW), DW data bits, STARVE_MAX (1..15) max consecutive
// cycles a pending CPU request may lose to video before it is forced through.
// Ports:
//   CLK, RST_n            clock, asynchronous active-low reset
//   CA, CDI, CDO          CPU address, write data, read data (valid with CACK)
//   CCS, CWE, CRD         CPU chip select, write strobe, read strobe
//   CWAIT                 combinational: CPU request pending and not granted this cycle
//   CACK                  one-cycle acknowledge, cycle after grant
//   VREQ, VA, VDO         video fetch request, address, read data
//   VVALID                VDO carries the data for last cycle's VREQ
//   VMISS                 last cycle's VREQ was dropped in favour of the CPU
//   BUSY                  post-reset clear running
// Build option: define NX1_VRAM_CLEAR_EN to zero the whole array after every reset release;
// without it BUSY is tied 0 and the array powers up undefined.
module nx1_vram_arb #(
    parameter int AW         = 11,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 8
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic [AW-1:0] CA,
    input  logic [DW-1:0] CDI,
    output logic [DW-1:0] CDO,
    input  logic          CCS,
    input  logic          CWE,
    input  logic          CRD,
    output logic          CWAIT,
    output logic          CACK,
    input  logic          VREQ,
    input  logic [AW-1:0] VA,
    output logic [DW-1:0] VDO,
    output logic          VVALID,
    output logic          VMISS,
    output logic          BUSY
);
    localparam int SW = 4;
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [DW-1:0] mem [2**AW];
    logic [SW-1:0] starve;
    logic          done;
    logic          busy;
    logic          cpu_req;
    logic          cpu_win;
    logic          vid_win;

    // done blocks re-service of a CCS assertion that is still held after its grant
    assign cpu_req = CCS & (CWE | CRD) & ~done;
    assign cpu_win = ~busy & cpu_req & (~VREQ | (starve == SMAX));
    assign vid_win = ~busy & VREQ & ~cpu_win;
    assign CWAIT   = cpu_req & ~cpu_win;
    assign BUSY    = busy;

`ifdef NX1_VRAM_CLEAR_EN
    logic [AW-1:0] clr_addr;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            busy     <= 1'b1;
            clr_addr <= '0;
        end else if (busy) begin
            clr_addr <= clr_addr + AW'(1);
            busy     <= (clr_addr != '1);
        end
    end

    always_ff @(posedge CLK) begin
        if (busy)
            mem[clr_addr] <= '0;
        else if (cpu_win && CWE)
            mem[CA] <= CDI;
    end
`else
    assign busy = 1'b0;

    always_ff @(posedge CLK) begin
        if (cpu_win && CWE)
            mem[CA] <= CDI;
    end
`endif

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            starve <= '0;
            done   <= 1'b0;
            CACK   <= 1'b0;
            VMISS  <= 1'b0;
            VVALID <= 1'b0;
            VDO    <= '0;
            CDO    <= '0;
        end else begin
            // counts only consecutive losses of a live request; any other cycle restarts it
            starve <= (vid_win && cpu_req) ? ((starve == SMAX) ? starve : starve + SW'(1)) : '0;
            done   <= CCS & (done | cpu_win);
            CACK   <= cpu_win;
            VMISS  <= cpu_win & VREQ;
            // during the clear, video fetches are answered with zero data
            VVALID <= vid_win | (busy & VREQ);
            if (busy && VREQ)
                VDO <= '0;
            else if (vid_win)
                VDO <= mem[VA];
            if (cpu_win && !CWE)
                CDO <= mem[CA];
        end
    end
endmodule

// File: tb/tb_nx1_vram_arb.sv
// tb_nx1_vram_arb: table-driven, directed and randomized checks of nx1_vram_arb against a cycle model.
module tb_nx1_vram_arb;
    localparam int AW = 11;
    localparam int DW = 8;
    localparam int SM = 8;
    localparam int N  = 1 << AW;

    logic          CLK = 0;
    logic          RST_n = 1;
    logic [AW-1:0] CA = '0;
    logic [DW-1:0] CDI = '0;
    logic [DW-1:0] CDO;
    logic          CCS = 0;
    logic          CWE = 0;
    logic          CRD = 0;
    logic          CWAIT;
    logic          CACK;
    logic          VREQ = 0;
    logic [AW-1:0] VA = '0;
    logic [DW-1:0] VDO;
    logic          VVALID;
    logic          VMISS;
    logic          BUSY;

    nx1_vram_arb #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .CLK(CLK), .RST_n(RST_n), .CA(CA), .CDI(CDI), .CDO(CDO),
        .CCS(CCS), .CWE(CWE), .CRD(CRD), .CWAIT(CWAIT), .CACK(CACK),
        .VREQ(VREQ), .VA(VA), .VDO(VDO), .VVALID(VVALID), .VMISS(VMISS), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int compared = 0;
    int mismatched = 0;

    // reference model: memory image plus the request bookkeeping the arbitration rules need
    logic [DW-1:0] ref_mem [N];
    int            starve_m;
    bit            done_m;
    logic [DW-1:0] cdo_m, vdo_m;
    bit            cack_m, vvalid_m, vmiss_m;
    logic          cwait_s;

    typedef struct packed {
        logic          ccs, cwe, crd, vreq;
        logic [AW-1:0] ca, va;
        logic [DW-1:0] cdi;
        logic          e_cwait, e_cack, e_vvalid, e_vmiss, chk_cdo;
        logic [DW-1:0] e_cdo;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic ccs, logic cwe, logic crd, logic vreq, int ca, int va, int cdi,
                                logic ew, logic ea, logic ev, logic em, logic cc, int ecdo);
        vec_t v;
        v.ccs = ccs; v.cwe = cwe; v.crd = crd; v.vreq = vreq;
        v.ca = AW'(ca); v.va = AW'(va); v.cdi = DW'(cdi);
        v.e_cwait = ew; v.e_cack = ea; v.e_vvalid = ev; v.e_vmiss = em;
        v.chk_cdo = cc; v.e_cdo = DW'(ecdo);
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock: called at a negedge with inputs already driven, returns at the next negedge
    task automatic cycle();
        logic          req, cw, vw, we, vreq, ccs;
        logic [AW-1:0] ca, va;
        logic [DW-1:0] cdi;
        #1;
        req = CCS && (CWE || CRD) && !done_m;
        cw  = req && (!VREQ || starve_m >= SM);
        vw  = VREQ && !cw;
        cwait_s = CWAIT;
        chk("cwait", CWAIT, 32'(req && !cw));
        ca = CA; va = VA; cdi = CDI; we = CWE; vreq = VREQ; ccs = CCS;
        @(posedge CLK);
        #1;
        cack_m   = cw;
        vmiss_m  = cw && vreq;
        vvalid_m = vw;
        if (vw) vdo_m = ref_mem[va];
        if (cw && we) ref_mem[ca] = cdi;
        if (cw && !we) cdo_m = ref_mem[ca];
        starve_m = (req && !cw) ? ((starve_m < SM) ? starve_m + 1 : SM) : 0;
        done_m   = ccs && (done_m || cw);
        chk("cack", CACK, 32'(cack_m));
        chk("vmiss", VMISS, 32'(vmiss_m));
        chk("vvalid", VVALID, 32'(vvalid_m));
        chk("vdo", VDO, 32'(vdo_m));
        chk("cdo", CDO, 32'(cdo_m));
        chk("busy", BUSY, 0);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST_n = 0;
        #1;
        chk("rst_cack", CACK, 0);
        chk("rst_vvalid", VVALID, 0);
        chk("rst_vmiss", VMISS, 0);
        chk("rst_cdo", CDO, 0);
        chk("rst_vdo", VDO, 0);
        starve_m = 0; done_m = 0; cack_m = 0; vvalid_m = 0; vmiss_m = 0;
        cdo_m = '0; vdo_m = '0;
        @(negedge CLK);
        RST_n = 1;
`ifdef NX1_VRAM_CLEAR_EN
        begin
            int n = 0;
            #1;
            while (BUSY && n <= 2 * N) begin
                n++;
                chk("clr_cwait", CWAIT, 32'(CCS && (CWE || CRD)));
                @(posedge CLK);
                @(negedge CLK);
                #1;
            end
            chk("clr_len", n, N);
            for (int a = 0; a < N; a++) ref_mem[a] = '0;
            if (VREQ) begin
                vvalid_m = 1;
                vdo_m = '0;
            end
        end
`else
        chk("busy_off", BUSY, 0);
`endif
    endtask

    initial begin
        #2;
        RST_n = 0;
        do_reset();

        // preload: each word holds the low bits of its own address
        for (int a = 0; a < N; a++) begin
            CCS = 1; CWE = 1; CRD = 0; CA = AW'(a); CDI = DW'(a); VREQ = 0;
            cycle();
            CCS = 0; CWE = 0;
            cycle();
        end

        for (int i = 0; i < SM; i++) vt.push_back(mk(1, 0, 1, 1, 'h010, i, 0, 1, 0, 1, 0, 0, 0));
        vt.push_back(mk(1, 0, 1, 1, 'h010, 'h001, 0, 0, 1, 0, 1, 1, 'h10));
        vt.push_back(mk(1, 0, 1, 1, 'h010, 'h002, 0, 0, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 1, 0, 0, 'h123, 0, 'hA5, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 1, 0, 'h123, 0, 0, 0, 1, 0, 0, 1, 'hA5));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 1, 0, 0, 'h7FF, 0, 'h3C, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(1, 1, 0, 0, 'h7FF, 0, 'h3C, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 1, 0, 0, 'h7FF, 0, 'h55, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 1, 0, 0, 'h7FF, 0, 'h55, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 1, 0, 0, 'h7FF, 0, 'h3C, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 1, 0, 'h7FF, 0, 0, 0, 1, 0, 0, 1, 'h3C));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) vt.push_back(mk(1, 1, 0, 1, 'h050, 4 + i, 'hEE, 1, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 'h050, 0, 'hEE, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 1, 0, 'h050, 0, 0, 0, 1, 0, 0, 1, 'h50));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (vt[i]) begin
            CCS = vt[i].ccs; CWE = vt[i].cwe; CRD = vt[i].crd; VREQ = vt[i].vreq;
            CA = vt[i].ca; VA = vt[i].va; CDI = vt[i].cdi;
            cycle();
            chk($sformatf("tbl%0d_cwait", i), cwait_s, vt[i].e_cwait);
            chk($sformatf("tbl%0d_cack", i), CACK, vt[i].e_cack);
            chk($sformatf("tbl%0d_vvalid", i), VVALID, vt[i].e_vvalid);
            chk($sformatf("tbl%0d_vmiss", i), VMISS, vt[i].e_vmiss);
            if (vt[i].chk_cdo) chk($sformatf("tbl%0d_cdo", i), CDO, vt[i].e_cdo);
        end

        // video streaming over the preloaded image
        for (int i = 0; i < 16; i++) begin
            CCS = 0; VREQ = 1; VA = AW'(i);
            cycle();
            chk("stream_vvalid", VVALID, 1);
            chk("stream_vdo", VDO, i);
        end
        VREQ = 0;
        cycle();

        // reset pulse while a write waits behind video; still-held CCS is served again afterwards
        CCS = 1; CWE = 1; CRD = 0; CA = 'h200; CDI = 'h11; VREQ = 1; VA = 0;
        cycle();
        cycle();
        VREQ = 0;
        #2;
        do_reset();
        cycle();
        chk("rst_reserve_cack", CACK, 1);
        CCS = 0; CWE = 0;
        cycle();

        for (int i = 0; i < 3000; i++) begin
            if (!(cwait_s && CCS && $urandom_range(0, 9) != 0)) begin
                CCS = ($urandom_range(0, 2) != 0);
                CWE = 1'($urandom_range(0, 1));
                CRD = 1'($urandom_range(0, 1));
                CA  = AW'($urandom_range(0, 63));
                CDI = DW'($urandom);
            end
            VREQ = ($urandom_range(0, 3) != 0);
            VA   = AW'($urandom_range(0, 63));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
